// File: rtl/csr_pkg.sv
// Shared CSR-bus definitions: modify-op encodings, GPIO register offsets and
// the read-modify-write helper used by every CSR peripheral.
package csr_pkg;

    typedef enum logic [2:0] {
        CSR_NONE  = 3'b000,
        CSR_WRITE = 3'b001,
        CSR_SET   = 3'b010,
        CSR_CLEAR = 3'b011
    } csr_op_e;

    localparam logic [11:0] GPIO_OUT   = 12'd0;
    localparam logic [11:0] GPIO_DIR   = 12'd1;
    localparam logic [11:0] GPIO_IN    = 12'd2;
    localparam logic [11:0] GPIO_RISE  = 12'd3;
    localparam logic [11:0] GPIO_FALL  = 12'd4;
    localparam logic [11:0] GPIO_IE    = 12'd5;
    localparam logic [11:0] GPIO_NREGS = 12'd6;

    // Ops with bit 2 set (and CSR_NONE) leave the register untouched.
    function automatic logic [31:0] csr_apply(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  op);
        case (op)
            CSR_WRITE: return wdata;
            CSR_SET:   return cur | wdata;
            CSR_CLEAR: return cur & ~wdata;
            default:   return cur;
        endcase
    endfunction

endpackage

// File: rtl/csr_gpio_if.sv
// Pipeline CSR bus as seen by one peripheral; rdata/valid from several
// peripherals are OR-combined upstream.
interface csr_gpio_if;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;

    modport master (
        output read, modify, wdata, addr,
        input  rdata, valid
    );

    modport slave (
        input  read, modify, wdata, addr,
        output rdata, valid
    );
endinterface

// File: rtl/gpio_sync_edge.sv
// Two-flop pad synchronizer plus edge detector; edges are suppressed for the
// first three cycles after reset so pads already high do not look like rises.
module gpio_sync_edge #(
    parameter int COUNT = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [COUNT-1:0] pins_in,
    output logic [COUNT-1:0] sync,
    output logic [COUNT-1:0] rise,
    output logic [COUNT-1:0] fall
);

    logic [COUNT-1:0] sync1_reg;
    logic [COUNT-1:0] sync2_reg;
    logic [COUNT-1:0] prev_reg;
    logic [1:0]       arm_cnt_reg;
    logic             armed;

    assign armed = (arm_cnt_reg == 2'd3);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_reg   <= '0;
            sync2_reg   <= '0;
            prev_reg    <= '0;
            arm_cnt_reg <= 2'd0;
        end else begin
            sync1_reg <= pins_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            if (!armed) begin
                arm_cnt_reg <= arm_cnt_reg + 2'd1;
            end
        end
    end

    assign sync = sync2_reg;

    for (genvar gi = 0; gi < COUNT; gi++) begin : g_edge
        assign rise[gi] = armed &  sync2_reg[gi] & ~prev_reg[gi];
        assign fall[gi] = armed & ~sync2_reg[gi] &  prev_reg[gi];
    end

endmodule

// File: rtl/csr_gpio.sv
// COUNT-line bidirectional GPIO on the CSR bus: OUT/DIR registers, synchronized
// inputs, sticky rise/fall pending flags and a registered level interrupt.
module csr_gpio
    import csr_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR = 12'hbc1,
    parameter int          COUNT     = 8,
    parameter logic [31:0] RESET_OUT = 32'h81,
    parameter logic [31:0] RESET_DIR = 32'hFF
) (
    input  logic             clk,
    input  logic             rstn,
    csr_gpio_if.slave        bus,
    input  logic [COUNT-1:0] pins_in,
    output logic [COUNT-1:0] pins_out,
    output logic [COUNT-1:0] pins_oe,
    output logic             irq
);

    logic [COUNT-1:0] out_reg,  out_next;
    logic [COUNT-1:0] dir_reg,  dir_next;
    logic [COUNT-1:0] rise_reg, rise_next;
    logic [COUNT-1:0] fall_reg, fall_next;
    logic [COUNT-1:0] ie_reg,   ie_next;
    logic [31:0]      rdata_reg;
    logic             valid_reg;
    logic             irq_reg;

    logic [COUNT-1:0] sync_in, rise_det, fall_det;
    logic [11:0]      offset;
    logic             hit;
    logic [31:0]      cur_val, new_val;
    logic [COUNT-1:0] new_bits;
    logic             sel_out, sel_dir, sel_rise, sel_fall, sel_ie;
    logic [COUNT-1:0] rise_clr, fall_clr;
    logic             unused_bits;

    gpio_sync_edge #(
        .COUNT (COUNT)
    ) u_sync_edge (
        .clk     (clk),
        .rstn    (rstn),
        .pins_in (pins_in),
        .sync    (sync_in),
        .rise    (rise_det),
        .fall    (fall_det)
    );

    // Unsigned wrap makes addresses below BASE_ADDR land far above the map.
    assign offset = bus.addr - BASE_ADDR;
    assign hit    = (offset < GPIO_NREGS);

    always_comb begin
        cur_val = '0;
        if (hit) begin
            case (offset)
                GPIO_OUT:  cur_val[COUNT-1:0] = out_reg;
                GPIO_DIR:  cur_val[COUNT-1:0] = dir_reg;
                GPIO_IN:   cur_val[COUNT-1:0] = sync_in;
                GPIO_RISE: cur_val[COUNT-1:0] = rise_reg;
                GPIO_FALL: cur_val[COUNT-1:0] = fall_reg;
                GPIO_IE:   cur_val[COUNT-1:0] = ie_reg;
                default:   cur_val = '0;
            endcase
        end
    end

    assign new_val  = csr_apply(cur_val, bus.wdata, bus.modify);
    assign new_bits = new_val[COUNT-1:0];

    assign sel_out  = hit && (offset == GPIO_OUT);
    assign sel_dir  = hit && (offset == GPIO_DIR);
    assign sel_rise = hit && (offset == GPIO_RISE);
    assign sel_fall = hit && (offset == GPIO_FALL);
    assign sel_ie   = hit && (offset == GPIO_IE);

    assign out_next = sel_out ? new_bits : out_reg;
    assign dir_next = sel_dir ? new_bits : dir_reg;
    assign ie_next  = sel_ie  ? new_bits : ie_reg;

    // Pending flags only respond to the clear op; write/set are dropped.
    assign rise_clr = (sel_rise && (bus.modify == CSR_CLEAR)) ? bus.wdata[COUNT-1:0] : '0;
    assign fall_clr = (sel_fall && (bus.modify == CSR_CLEAR)) ? bus.wdata[COUNT-1:0] : '0;

    // A hardware edge in the same cycle as a software clear keeps the bit set.
    for (genvar gi = 0; gi < COUNT; gi++) begin : g_pending
        assign rise_next[gi] = rise_det[gi] | (rise_reg[gi] & ~rise_clr[gi]);
        assign fall_next[gi] = fall_det[gi] | (fall_reg[gi] & ~fall_clr[gi]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_reg   <= RESET_OUT[COUNT-1:0];
            dir_reg   <= RESET_DIR[COUNT-1:0];
            rise_reg  <= '0;
            fall_reg  <= '0;
            ie_reg    <= '0;
            rdata_reg <= '0;
            valid_reg <= 1'b0;
            irq_reg   <= 1'b0;
        end else begin
            out_reg   <= out_next;
            dir_reg   <= dir_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            ie_reg    <= ie_next;
            rdata_reg <= cur_val;
            valid_reg <= hit;
            irq_reg   <= |((rise_reg | fall_reg) & ie_reg);
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.valid = valid_reg;
    assign pins_out  = out_reg;
    assign pins_oe   = dir_reg;
    assign irq       = irq_reg;

    // The read strobe is informational only; decode is purely on addr.
    assign unused_bits = ^{bus.read, new_val};

endmodule
